// File: rtl/pri_pkg.sv
// pri_pkg: index-width helper and skid-buffer state encoding shared by the priority encode/decode blocks
package pri_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} skid_state_t;
  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/pri_decoder_stream_skid_buf.sv
// skid_buf: generic 2-entry valid/ready skid buffer; in_ready comes straight from state, never from out_ready
module skid_buf
  import pri_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);
  skid_state_t state_q, state_d;
  logic [DW-1:0] main_q, main_d, skid_q, skid_d;
  logic acc, drn;
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign acc = in_valid & in_ready;
  assign drn = out_valid & out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        state_d = acc ? ONE : EMPTY;
        main_d  = acc ? in_data : main_q;
      end
      ONE: begin
        state_d = (acc && !drn) ? TWO : (!acc && drn) ? EMPTY : ONE;
        main_d  = (acc && drn) ? in_data : main_q;
        skid_d  = (acc && !drn) ? in_data : skid_q;
      end
      TWO: begin
        state_d = drn ? ONE : TWO;
        main_d  = drn ? skid_q : main_q;
      end
      default: state_d = EMPTY;
    endcase
  end
endmodule

// File: rtl/pri_decoder_stream.sv
// pri_decoder_stream: index -> one-hot decoder behind a skid buffer; PRI_DECODER_RANGE_CHECK_EN adds out_err
module pri_decoder_stream
  import pri_pkg::*;
#(
  parameter  int IP_WIDTH = 4,
  localparam int OP_WIDTH = idx_width(IP_WIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_en,
  input  logic [OP_WIDTH-1:0] in_idx,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IP_WIDTH-1:0] out_onehot
`ifdef PRI_DECODER_RANGE_CHECK_EN
  ,
  output logic                out_err
`endif
);
  function automatic logic [IP_WIDTH-1:0] decode(input logic en, input logic [OP_WIDTH-1:0] idx);
    return (en && 32'(idx) < IP_WIDTH) ? IP_WIDTH'(1) << idx : '0;
  endfunction
`ifdef PRI_DECODER_RANGE_CHECK_EN
  localparam int DW = IP_WIDTH + 1;
  logic [DW-1:0] in_word, out_word;
  assign in_word = {in_en && 32'(in_idx) >= IP_WIDTH, decode(in_en, in_idx)};
  assign {out_err, out_onehot} = out_word;
`else
  localparam int DW = IP_WIDTH;
  logic [DW-1:0] in_word, out_word;
  assign in_word    = decode(in_en, in_idx);
  assign out_onehot = out_word;
`endif
  skid_buf #(.DW(DW)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_word)
  );
endmodule
